// File: rtl/psum_drain_ctrl.sv
// Drains psum vectors from the corelet OFIFO into the psum SRAM at consecutive addresses.
// Optional per-lane ReLU clamp at capture when PSUM_DRAIN_RELU_EN is defined.
module psum_drain_ctrl #(
   parameter int unsigned col     = 8,
   parameter int unsigned psum_bw = 16,
   parameter int unsigned addr_bw = 11
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [addr_bw-1:0]       base_addr,
   input  logic [addr_bw-1:0]       num_vec,
   input  logic                     ofifo_valid,
   output logic                     ofifo_rd,
   input  logic [psum_bw*col-1:0]   psum_in,
   output logic                     sram_cen,
   output logic                     sram_wen,
   output logic [addr_bw-1:0]       sram_addr,
   output logic [psum_bw*col-1:0]   sram_d,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned CNT_W  = addr_bw + 1;
   localparam int unsigned DATA_W = psum_bw * col;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [addr_bw-1:0]  base_q;
   logic [CNT_W-1:0]    num_q;
   logic [CNT_W-1:0]    rd_cnt;
   logic [CNT_W-1:0]    wr_cnt;
   logic                rd_q;
   logic                job_start_c;
   logic [DATA_W-1:0]   cap_d_c;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and the combinational pop request
   always_comb begin
      state_nxt   = state;
      ofifo_rd    = 1'b0;
      job_start_c = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               job_start_c = 1'b1;
               state_nxt   = (num_vec == '0) ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            ofifo_rd = ofifo_valid && (rd_cnt < num_q);
            // Leave on the final pop so FLUSH only waits for the two-stage write pipe
            if (ofifo_rd && ((rd_cnt + CNT_W'(1)) == num_q)) begin
               state_nxt = FLUSH;
            end else if (rd_cnt >= num_q) begin
               state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            if ((wr_cnt == num_q) && !rd_q) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Job parameters, pop/write counters and the pop-valid delay stage
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_q <= '0;
         num_q  <= '0;
         rd_cnt <= '0;
         wr_cnt <= '0;
         rd_q   <= 1'b0;
      end else begin
         rd_q <= ofifo_rd;
         if (job_start_c) begin
            base_q <= base_addr;
            num_q  <= CNT_W'(num_vec);
            rd_cnt <= '0;
            wr_cnt <= '0;
         end else begin
            if (ofifo_rd) begin
               rd_cnt <= rd_cnt + CNT_W'(1);
            end
            if (rd_q) begin
               wr_cnt <= wr_cnt + CNT_W'(1);
            end
         end
      end
   end

   // Capture data, optionally clamping negative lanes to zero
   always_comb begin
      cap_d_c = psum_in;
`ifdef PSUM_DRAIN_RELU_EN
      for (int unsigned l = 0; l < col; l++) begin
         if (psum_in[l*psum_bw + psum_bw - 1]) begin
            cap_d_c[l*psum_bw +: psum_bw] = '0;
         end
      end
`endif
   end

   // SRAM write port; address and data hold between writes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sram_cen  <= 1'b1;
         sram_wen  <= 1'b1;
         sram_addr <= '0;
         sram_d    <= '0;
      end else begin
         sram_cen <= ~rd_q;
         sram_wen <= ~rd_q;
         if (rd_q) begin
            sram_addr <= base_q + wr_cnt[addr_bw-1:0];
            sram_d    <= cap_d_c;
         end
      end
   end

   // Status flags registered from the next state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_nxt != IDLE);
         done <= (state_nxt == DONE);
      end
   end

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Bench for psum_drain_ctrl: bench-side OFIFO, write/timing reference model, immediate assertions.
// Honours PSUM_DRAIN_RELU_EN the same way as the design.
module tb_psum_drain_ctrl;

   localparam int unsigned AW    = 11;
   localparam int unsigned PW    = 16;
   localparam int unsigned LANES = 8;
   localparam int unsigned DW    = PW * LANES;
`ifdef PSUM_DRAIN_RELU_EN
   localparam logic [PW-1:0] EXP_NEG = 16'h0000;
`else
   localparam logic [PW-1:0] EXP_NEG = 16'hFFFB;
`endif

   logic          clk;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW-1:0] num_vec;
   logic          ofifo_valid;
   logic          ofifo_rd;
   logic [DW-1:0] psum_in;
   logic          sram_cen;
   logic          sram_wen;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_d;
   logic          busy;
   logic          done;

   int            n_pass;
   int            n_total;
   logic [AW-1:0] g_addr;
   logic [DW-1:0] g_d;

   psum_drain_ctrl #(.col(LANES), .psum_bw(PW), .addr_bw(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .num_vec    (num_vec),
      .ofifo_valid(ofifo_valid),
      .ofifo_rd   (ofifo_rd),
      .psum_in    (psum_in),
      .sram_cen   (sram_cen),
      .sram_wen   (sram_wen),
      .sram_addr  (sram_addr),
      .sram_d     (sram_d),
      .busy       (busy),
      .done       (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [DW-1:0] rand_vec();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Expected SRAM contents for a popped vector
   function automatic logic [DW-1:0] relu_model(input logic [DW-1:0] v);
      logic [DW-1:0] r;
      r = v;
`ifdef PSUM_DRAIN_RELU_EN
      for (int l = 0; l < int'(LANES); l++) begin
         if ($signed(v[l*PW +: PW]) < 0) r[l*PW +: PW] = '0;
      end
`endif
      return r;
   endfunction

   function automatic logic [DW-1:0] make_vec(input int dmode, input int k);
      logic [DW-1:0] v;
      v = '0;
      for (int l = 0; l < int'(LANES); l++) begin
         case (dmode)
            0:       v[l*PW +: PW] = PW'(k);
            2:       v[l*PW +: PW] = (l % 2 == 0) ? 16'hFFFB : 16'h0007;
            default: v[l*PW +: PW] = PW'($urandom());
         endcase
      end
      return v;
   endfunction

   // One job; cycle 0 is the cycle in which start is presented
   task automatic run_job(input logic [AW-1:0] base, input int num, input int vmode,
                          input int dmode, input bit poke, input int abort_at);
      logic [DW-1:0] exp_q[$];
      int            pop_cyc[$];
      logic [DW-1:0] vec;
      logic [DW-1:0] pend_vec;
      bit            pend, fin, done_seen, aborted, exp_wr, exp_rd, exp_done;
      int            pops, writes, last_pop, budget;
      pend = 0; fin = 0; done_seen = 0; aborted = 0;
      pops = 0; writes = 0; last_pop = -10;
      pend_vec = '0;
      budget = 30 + num * 40;
      @(negedge clk);
      for (int c = 0; c < budget; c++) begin
         exp_wr = (pop_cyc.size() > 0) && (pop_cyc[0] + 2 == c);
         chk("sram_cen", sram_cen, !exp_wr);
         chk("sram_wen", sram_wen, !exp_wr);
         if (exp_wr) begin
            g_addr = base + AW'(writes);
            g_d    = exp_q.pop_front();
            void'(pop_cyc.pop_front());
            writes++;
            if (dmode == 2) begin
               chk("lane_neg5", sram_d[PW-1:0], EXP_NEG);
               chk("lane_pos7", sram_d[2*PW-1:PW], 16'h0007);
            end
         end
         chk("sram_addr", sram_addr, g_addr);
         chk("sram_d", sram_d, g_d);
         exp_done = (num == 0) ? (c == 1) : (pops == num && c == last_pop + 3);
         chk("done", done, exp_done);
         chk("busy", busy, (c >= 1) && !done_seen);
         if (done_seen) begin
            fin = 1; start = 0; ofifo_valid = 0;
            break;
         end
         if (exp_done) done_seen = 1;
         if (abort_at > 0 && writes == abort_at) begin
            reset = 1'b0;
            #1;
            chk("abort_rd", ofifo_rd, 1'b0);
            chk("abort_cen", sram_cen, 1'b1);
            chk("abort_wen", sram_wen, 1'b1);
            chk("abort_addr", sram_addr, '0);
            chk("abort_d", sram_d, '0);
            chk("abort_busy", busy, 1'b0);
            chk("abort_done", done, 1'b0);
            g_addr = '0; g_d = '0;
            start = 0; ofifo_valid = 0;
            @(negedge clk);
            @(negedge clk);
            reset = 1'b1;
            aborted = 1;
            break;
         end
         if (c == 0) begin
            start = 1; base_addr = base; num_vec = AW'(num);
         end else if (poke && c == 2) begin
            start = 1; base_addr = AW'($urandom()); num_vec = AW'($urandom_range(1, 9));
         end else begin
            start = 0; base_addr = AW'($urandom()); num_vec = AW'($urandom());
         end
         psum_in = pend ? pend_vec : rand_vec();
         pend = 0;
         case (vmode)
            0:       ofifo_valid = 1'b1;
            1:       ofifo_valid = (c % 2 == 1);
            default: ofifo_valid = ($urandom_range(0, 3) != 0);
         endcase
         #1;
         exp_rd = ofifo_valid && (c >= 1) && (pops < num);
         chk("ofifo_rd", ofifo_rd, exp_rd);
         if (exp_rd) begin
            vec = make_vec(dmode, pops);
            pend_vec = vec;
            pend = 1;
            exp_q.push_back(relu_model(vec));
            pop_cyc.push_back(c);
            pops++;
            last_pop = c;
         end
         @(negedge clk);
      end
      if (!aborted) begin
         chk("job_finished", fin, 1'b1);
         chk("pop_count", pops, num);
         chk("write_count", writes, num);
      end
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      g_addr = '0; g_d = '0;
      reset = 1'b0; start = 1'b1; ofifo_valid = 1'b1;
      base_addr = 11'h123; num_vec = 11'd5; psum_in = rand_vec();
      repeat (3) @(negedge clk);
      chk("rst_rd", ofifo_rd, 1'b0);
      chk("rst_cen", sram_cen, 1'b1);
      chk("rst_wen", sram_wen, 1'b1);
      chk("rst_addr", sram_addr, '0);
      chk("rst_d", sram_d, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;

      run_job(11'h010, 4, 0, 0, 1'b0, 0);
      run_job(11'h055, 3, 1, 1, 1'b0, 0);
      run_job(11'h7FE, 4, 0, 1, 1'b0, 0);
      run_job(11'h020, 0, 0, 1, 1'b0, 0);
      run_job(11'h030, 6, 2, 1, 1'b1, 0);
      run_job(11'h200, 5, 0, 1, 1'b0, 2);
      run_job(11'h100, 2, 0, 1, 1'b0, 0);
      run_job(11'h300, 2, 0, 2, 1'b0, 0);
      for (int j = 0; j < 6; j++) begin
         run_job(AW'($urandom()), int'($urandom_range(1, 12)), 2, 1, 1'b0, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
